// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder used once per SHIFT cycle by serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, result published in DONE.
// Optional macro SERIAL_ADDER_OVF_EN adds the o_overflow signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_sum;
    logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    full_adder u_full_adder (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // NOTE: every register here, datapath included, is cleared by reset so an
    // aborted addition leaves nothing behind; all state uses non-blocking <=.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q      <= 1'b0;
            o_overflow <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_sh    <= i_a;
                        b_sh    <= i_b;
                        carry   <= i_cin;
                        sum_sh  <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB.
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                    carry   <= fa_cout;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_ADDER_OVF_EN
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        ovf_q <= carry ^ fa_cout;
`endif
                        o_busy <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    o_sum  <= sum_sh;
                    o_cout <= carry;
`ifdef SERIAL_ADDER_OVF_EN
                    o_overflow <= ovf_q;
`endif
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomised self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start8),
        .i_a     (a8),
        .i_b     (b8),
        .i_cin   (cin8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8),
        .o_cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_overflow (ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .i_cin   (cin1),
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
        .o_cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_overflow (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one WIDTH=8 addition and counts edges after the accept edge until o_done.
    task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            output int edges);
        a8 = a;
        b8 = b;
        cin8 = cin;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        edges = 0;
        while (edges < 40 && !done8) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b, expected all 0",
                     busy8, done8, sum8, cout8);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b, expected all 0",
                     busy1, done1, sum1, cout1);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b expected 0", ovf8);
        end
`endif
        rst_n = 1'b1;
    endtask

    // Start is raised in the same step as reset release: the first edge must accept it.
    task automatic test_basic();
        int edges;
        int busy_cnt;
        bit partial;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        partial = 1'b0;
        edges = 0;
        while (edges < 40 && !done8) begin
            tick();
            edges++;
            if (busy8) busy_cnt++;
            if (!done8 && sum8 !== 8'h00) partial = 1'b1;
        end
        n_checks++;
        if (edges !== 9) begin
            n_fail++;
            $display("FAIL basic_latency: done after edge %0d, expected edge 9", edges);
        end
        n_checks++;
        if (busy_cnt !== 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected 8", busy_cnt);
        end
        n_checks++;
        if (partial !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_partial: o_sum changed before o_done");
        end
        n_checks++;
        if (sum8 !== 8'h10 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got sum=%h cout=%b expected sum=10 cout=0", sum8, cout8);
        end
        tick();
        n_checks++;
        if (done8 !== 1'b0 || sum8 !== 8'h10) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: got done=%b sum=%h expected done=0 sum=10",
                     done8, sum8);
        end
    endtask

    task automatic test_overflow();
        int edges;
        run_add8(8'hFF, 8'h01, 1'b0, edges);
        n_checks++;
        if (edges !== 9 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_ff_01: got edge=%0d sum=%h cout=%b expected edge=9 sum=00 cout=1",
                     edges, sum8, cout8);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_ff_01: got %b expected 0", ovf8);
        end
`endif
        run_add8(8'h7F, 8'h01, 1'b0, edges);
        n_checks++;
        if (sum8 !== 8'h80 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL pos_ovf_7f_01: got sum=%h cout=%b expected sum=80 cout=0", sum8, cout8);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_7f_01: got %b expected 1", ovf8);
        end
`endif
        run_add8(8'h80, 8'h80, 1'b0, edges);
        n_checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_ovf_80_80: got sum=%h cout=%b expected sum=00 cout=1", sum8, cout8);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_80_80: got %b expected 1", ovf8);
        end
`endif
        run_add8(8'hA5, 8'h5A, 1'b1, edges);
        n_checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_chain_a5_5a_1: got sum=%h cout=%b expected sum=00 cout=1",
                     sum8, cout8);
        end
    endtask

    // Start pulses during SHIFT and during DONE must not be queued or alter the result.
    task automatic test_ignore_start();
        int idle_busy;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        tick(); tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n_checks++;
        if (done8 !== 1'b1 || sum8 !== 8'hFF || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_result: got done=%b sum=%h cout=%b expected done=1 sum=ff cout=1",
                     done8, sum8, cout8);
        end
        idle_busy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy8 || done8 || sum8 !== 8'hFF) idle_busy++;
        end
        n_checks++;
        if (idle_busy !== 0) begin
            n_fail++;
            $display("FAIL ignore_no_queue: %0d cycles with activity or changed sum, expected 0",
                     idle_busy);
        end
    endtask

    task automatic test_reset_abort();
        int edges;
        int stray;
        a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_async_clear: got busy=%b done=%b sum=%h cout=%b expected all 0",
                     busy8, done8, sum8, cout8);
        end
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8 || busy8) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d cycles with busy/done after abort, expected 0", stray);
        end
        run_add8(8'h03, 8'h04, 1'b0, edges);
        n_checks++;
        if (edges !== 9 || sum8 !== 8'h07 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_restart: got edge=%0d sum=%h cout=%b expected edge=9 sum=07 cout=0",
                     edges, sum8, cout8);
        end
    endtask

    task automatic test_width1();
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_edge0: got busy=%b done=%b expected busy=1 done=0", busy1, done1);
        end
        tick();
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_edge1: got busy=%b done=%b expected busy=0 done=0", busy1, done1);
        end
        tick();
        n_checks++;
        if (done1 !== 1'b1 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_111: got done=%b sum=%b cout=%b expected done=1 sum=1 cout=1",
                     done1, sum1, cout1);
        end
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        n_checks++;
        if (done1 !== 1'b1 || sum1 !== 1'b1 || cout1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_100: got done=%b sum=%b cout=%b expected done=1 sum=1 cout=0",
                     done1, sum1, cout1);
        end
    endtask

    // Start held high: every done must be WIDTH+2 edges after the previous one.
    task automatic test_back_to_back();
        logic [8:0] expct;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         edges;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
        expct = {1'b0, ra} + {1'b0, rb} + 9'(rc);
        tick();
        for (int i = 0; i < 1000; i++) begin
            edges = 0;
            do begin
                tick();
                edges++;
            end while (!done8 && edges < 20);
            n_checks++;
            if (edges !== ((i == 0) ? 9 : 10)) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: done after %0d edges expected %0d",
                         i, edges, (i == 0) ? 9 : 10);
            end
            n_checks++;
            if ({cout8, sum8} !== expct) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: %h+%h+%b got %h expected %h",
                         i, ra, rb, rc, {cout8, sum8}, expct);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++;
            if (ovf8 !== ((ra[7] == rb[7]) && (expct[7] != ra[7]))) begin
                n_fail++;
                $display("FAIL b2b_ovf[%0d]: got %b", i, ovf8);
            end
`endif
            if (!done8) break;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a8 = ra; b8 = rb; cin8 = rc;
            expct = {1'b0, ra} + {1'b0, rb} + 9'(rc);
        end
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_width1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 The block SHALL have port i_a, input, WIDTH bits: operand A, captured on the accepted start.
REQ-006 The block SHALL have port i_b, input, WIDTH bits: operand B, captured on the accepted start.
REQ-007 The block SHALL have port i_cin, input, 1 bit: carry-in, captured on the accepted start.
REQ-008 The block SHALL have port o_busy, output, 1 bit: high while in SHIFT.
REQ-009 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port o_sum, output, WIDTH bits: the result, held until the next accepted start.
REQ-011 The block SHALL have port o_cout, output, 1 bit: carry-out of the MSB, held with o_sum.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with i_start=1, the block SHALL, on the edge, latch i_a, i_b and i_cin into shift and carry registers, clear the bit counter to 0, and enter SHIFT.
REQ-014 In each SHIFT cycle, the block SHALL add the operand LSBs plus the carry register, shift the result bit into the sum register from the MSB side, shift both operands right, update the carry register, and increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE, where o_done=1 for one cycle; the next state SHALL be IDLE.
REQ-016 With start accepted at edge N, o_done SHALL be high during the cycle following edge N+WIDTH+1, and o_sum/o_cout SHALL be valid from that cycle.
REQ-017 The block SHALL produce o_sum = (i_a + i_b + i_cin) mod 2^WIDTH and o_cout = bit WIDTH of that sum.
REQ-018 The block SHALL ignore i_start in SHIFT and DONE; no queuing.
REQ-019 The block SHALL keep o_sum and o_cout stable from DONE until the next accepted start, and SHALL NOT expose partial sums during SHIFT.
REQ-020 The block SHALL give back-to-back operation a throughput of one addition per WIDTH+2 cycles.

Reset
REQ-021 When i_rst_n=0, the block SHALL immediately set the state to IDLE, clear all registers, and drive o_busy=0, o_done=0, o_sum=0 and o_cout=0.
REQ-022 A reset during SHIFT SHALL abort the operation, and the block SHALL NOT produce any o_done pulse for it.
REQ-023 On release of reset, the block SHALL be able to accept i_start on the first rising edge at which i_rst_n=1.

Configuration
REQ-024 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output o_overflow, 1 bit, giving two's-complement signed overflow (carry into MSB XOR carry out of MSB), registered and held like o_sum; reset value 0.
REQ-025 Without SERIAL_ADDER_OVF_EN, the port and its logic SHALL be absent, with no other behavioural difference.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the constant SERIAL_ADDER_DEFAULT_WIDTH=8.
REQ-027 The per-bit addition SHALL be a single instantiated sub-module, full_adder (inputs a, b, cin; outputs sum, cout); the counter width SHALL be $clog2(WIDTH+1).

Verification (WIDTH=8 unless stated)
REQ-028 Scenario 1: A=0x0F, B=0x01, cin=0, start at edge 0 -> o_busy high for 8 cycles; o_done pulse after edge 9; o_sum=0x10, o_cout=0.
REQ-029 Scenario 2: A=0xFF, B=0x01, cin=0 -> o_sum=0x00, o_cout=1, o_overflow=0; A=0x7F, B=0x01 -> o_sum=0x80, o_cout=0, o_overflow=1 (OVF_EN build).
REQ-030 Scenario 3: A=0xFF, B=0xFF, cin=1 -> o_sum=0xFF, o_cout=1; then start pulsed again mid-SHIFT with A=0x01 -> ignored, result unchanged.
REQ-031 Scenario 4: i_rst_n pulsed low after 4 SHIFT cycles -> outputs 0 immediately, no o_done; new start after release (A=0x03, B=0x04) -> o_sum=0x07.
REQ-032 Scenario 5: WIDTH=1, A=1, B=1, cin=1 -> o_done after edge 2, o_sum=1, o_cout=1.
REQ-033 Scenario 6: 1000 random operands with i_start held high -> every result matches the reference sum and o_done occurs every 10 cycles.
